gb_write_ctrl: RTL and testbench
================================

# gb_write_ctrl

Global-buffer write controller sitting directly downstream of the write-request arbiter. It owns the `State_Wr` handshake state that the arbiter samples. It consumes the arbiter's registered `Wr_Req`/`Wr_ID`, grants the selected source (weight, weight-flag, activation, activation-flag), accepts a fixed-length burst of data beats, and drives the GB SRAM write port at addresses derived from the ID.

## Interface
- `DATA_W`, 64, width of one data beat and of the GB word.
- `BEAT_W`, 4, beat-counter width; burst length is 2**`BEAT_W` beats (16 by default).
- `TIMEOUT`, 255, maximum number of cycles to wait in `READY_TO_WRITE` for the first beat; range 1..255.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `Wr_Req` in 1: registered request from the arbiter.
- `Wr_ID` in 6: ID of the selected requester; `[5:4]` is the source type, `[3:0]` is the sub-ID.
- `Wr_Dat_In` in `DATA_W`: data beat from the granted source.
- `Wr_Dat_Vld` in 1: `Wr_Dat_In` is valid.
- `State_Wr` out 2: IDLE=00, REQ_READY=01, READY_TO_WRITE=11, WRITE=10; fed back to the arbiter.
- `Wr_Grant` out 1: one-cycle pulse; the source selected by `Wr_Grant_ID` may start sending.
- `Wr_Grant_ID` out 6: latched ID of the current burst.
- `Wr_Dat_Rdy` out 1: controller accepts a beat this cycle.
- `GB_We` out 1: GB write strobe.
- `GB_Addr` out 6+`BEAT_W`: GB word address, {`Cur_ID`, beat}.
- `GB_Dat` out `DATA_W`: GB write data.
- `Wr_Done` out 1: one-cycle pulse, coincident with the final `GB_We` of a burst.
- `Wr_Abort` out 1: one-cycle pulse when the first-beat timeout expires.

## Operation
- **IDLE**
  - If `Wr_Req`=1: latch `Wr_ID` into `Cur_ID` and go to REQ_READY.
  - `Wr_Req` is ignored in every other state.
  - `Wr_ID` is sampled only on this transition.
- **REQ_READY** (exactly 1 cycle)
  - `Wr_Grant`=1 and `Wr_Grant_ID`=`Cur_ID`.
  - Go to READY_TO_WRITE.
- **READY_TO_WRITE**
  - `Wr_Dat_Rdy`=1; the wait counter increments each cycle.
  - On `Wr_Dat_Vld`=1: accept beat 0, clear the wait counter, go to WRITE.
  - If the counter reaches `TIMEOUT` with no valid beat: pulse `Wr_Abort`, go to IDLE, make no GB write.
- **WRITE**
  - `Wr_Dat_Rdy`=1.
  - Each `Wr_Dat_Vld`=1 accepts one beat and increments the beat counter. Gaps in `Wr_Dat_Vld` are allowed and hold the counter; there is no timeout in this state.
  - Accepting beat 2**`BEAT_W`−1 moves the FSM to IDLE on the next edge. The beat counter wraps to 0 on that transition.
- **Accepted beat** (`Wr_Dat_Vld`&`Wr_Dat_Rdy`)
  - Registers `GB_We`=1, `GB_Addr`={`Cur_ID`, beat}, `GB_Dat`=`Wr_Dat_In` for the next cycle.
  - For the final beat, `Wr_Done`=1 in that same next cycle.
- `Wr_Dat_Rdy` is a decode of the state: it is 1 only in READY_TO_WRITE and WRITE. `Wr_Dat_Vld` presented in IDLE or REQ_READY is dropped.
- `GB_Addr`/`GB_Dat` hold their last value when `GB_We`=0.

## Timing
- **Reset values** (applied on the first edge with `rst`=1): `State_Wr`=IDLE, `Wr_Grant`=0, `Wr_Grant_ID`=0, `GB_We`=0, `GB_Addr`=0, `GB_Dat`=0, `Wr_Done`=0, `Wr_Abort`=0. Counters and `Cur_ID` are also 0.
- **Reset mid-burst:** the burst is abandoned, with no `Wr_Done`. A `GB_We` registered in the reset cycle is cleared, so `GB_We`=0 on the following cycle.
- **Arbiter pipeline:** the arbiter registers `Wr_Req` one cycle after it sees IDLE. It keeps `Wr_Req`=1 for one extra cycle after this block leaves IDLE; that extra cycle is ignored because the state is REQ_READY.
  - On return to IDLE, the first-cycle `Wr_Req` is 0.
  - The earliest new acceptance is therefore the 2nd IDLE cycle.
- **Request latency:** `Wr_Req` sampled at edge N → REQ_READY (grant) in cycle N+1 → `Wr_Dat_Rdy` from cycle N+2.
- **Write latency:** a beat accepted in cycle k → `GB_We` in cycle k+1.
  - A burst with no gaps: grant at cycle g, beats in g+1..g+16, GB writes in g+2..g+17, `Wr_Done` at g+17, IDLE from g+17.
- **Timeout:** the wait counter starts at 0 on entry to READY_TO_WRITE. `Wr_Abort` is asserted in the cycle after TIMEOUT consecutive cycles with no valid beat, and the state is IDLE in that same cycle.
- **Simultaneous events:** a valid beat in the same cycle as the counter expiry is accepted, and the timeout is cancelled.

## Test plan
- **Single burst:** `Wr_Req`=1 with `Wr_ID`=0x25, then 16 back-to-back beats with data=beat index.
  - Required: exactly one `Wr_Grant` with ID 0x25.
  - `GB_We` on addresses 0x250..0x25F, data 0..15.
  - `Wr_Done` coincident with address 0x25F.
  - `State_Wr` sequence 00,01,11,10…,00.
- **Gapped burst:** ID 0x3F, `Wr_Dat_Vld` toggling 1,0,1,0.
  - Required: 16 writes to 0x3F0..0x3FF, no address skipped or repeated, `Wr_Done` once.
- **Timeout:** with `TIMEOUT`=8, grant ID 0x10 and never assert `Wr_Dat_Vld`.
  - Required: `Wr_Abort` pulse 8 cycles after entering READY_TO_WRITE, no `GB_We`, back to IDLE.
  - A following request for ID 0x11 writes 0x110..0x11F.
- **Stale request:** keep `Wr_Req`=1 with `Wr_ID`=0x05 for one cycle after grant, changing `Wr_ID` to 0x06.
  - Required: the burst uses 0x05, and no second grant occurs until the next IDLE acceptance.
- **Reset mid-burst:** assert `rst` after beat 7 of ID 0x2A.
  - Required: all outputs at reset values, `GB_We`=0 from the cycle after reset, no `Wr_Done`.
  - A new request for ID 0x2A restarts at 0x2A0.
- **Back-to-back requests:** from IDs 0x01 and 0x30.
  - Required: the second grant comes no earlier than the 2nd IDLE cycle after the first `Wr_Done`, and the writes do not overlap.

Source files
------------

// File: rtl/gb_write_ctrl.sv
// Global-buffer write controller: grants one requester at a time, accepts a fixed-length
// burst of beats and writes them to the GB SRAM at {ID, beat}.
module gb_write_ctrl #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BEAT_W  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Wr_Req,
  input  logic [5:0]            Wr_ID,
  input  logic [DATA_W-1:0]     Wr_Dat_In,
  input  logic                  Wr_Dat_Vld,
  output logic [1:0]            State_Wr,
  output logic                  Wr_Grant,
  output logic [5:0]            Wr_Grant_ID,
  output logic                  Wr_Dat_Rdy,
  output logic                  GB_We,
  output logic [6+BEAT_W-1:0]   GB_Addr,
  output logic [DATA_W-1:0]     GB_Dat,
  output logic                  Wr_Done,
  output logic                  Wr_Abort
);

  localparam int unsigned ID_W   = 6;
  localparam int unsigned WAIT_W = 8;

  // Encoding is observed directly by the arbiter.
  typedef enum logic [1:0] {
    IDLE           = 2'b00,
    REQ_READY      = 2'b01,
    READY_TO_WRITE = 2'b11,
    WRITE          = 2'b10
  } state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     cur_id;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                accept, last_beat, expire, latch_id;

  // Next-state and per-cycle control decode
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_beat  = 1'b0;
    expire     = 1'b0;
    latch_id   = 1'b0;
    case (state)
      IDLE: begin
        if (Wr_Req) begin
          latch_id   = 1'b1;
          state_next = REQ_READY;
        end
      end
      REQ_READY: state_next = READY_TO_WRITE;
      READY_TO_WRITE: begin
        // A beat arriving on the expiry cycle wins over the timeout.
        if (Wr_Dat_Vld) begin
          accept     = 1'b1;
          state_next = WRITE;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (Wr_Dat_Vld) begin
          accept = 1'b1;
          if (beat_cnt == '1) begin
            last_beat  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_id     <= '0;
      beat_cnt   <= '0;
      wait_cnt   <= '0;
      Wr_Grant   <= 1'b0;
      Wr_Dat_Rdy <= 1'b0;
      GB_We      <= 1'b0;
      GB_Addr    <= '0;
      GB_Dat     <= '0;
      Wr_Done    <= 1'b0;
      Wr_Abort   <= 1'b0;
    end else begin
      state      <= state_next;
      Wr_Grant   <= (state_next == REQ_READY);
      Wr_Dat_Rdy <= (state_next == READY_TO_WRITE) || (state_next == WRITE);
      GB_We      <= accept;
      Wr_Done    <= last_beat;
      Wr_Abort   <= expire;
      if (latch_id) cur_id <= Wr_ID;
      if (state == READY_TO_WRITE && !accept && !expire) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                               wait_cnt <= '0;
      if (accept) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
        GB_Addr  <= {cur_id, beat_cnt};
        GB_Dat   <= Wr_Dat_In;
      end
    end
  end

  assign State_Wr    = state;
  assign Wr_Grant_ID = cur_id;

endmodule

// File: tb/tb_gb_write_ctrl.sv
// Bench for gb_write_ctrl: table of bursts plus hand-written timeout and reset sequences,
// with a scoreboard of expected GB writes and grants checked by a negedge monitor.
module tb_gb_write_ctrl;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BEAT_W  = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned ADDR_W  = 6 + BEAT_W;

  logic                clk;
  logic                rst;
  logic                Wr_Req;
  logic [5:0]          Wr_ID;
  logic [DATA_W-1:0]   Wr_Dat_In;
  logic                Wr_Dat_Vld;
  logic [1:0]          State_Wr;
  logic                Wr_Grant;
  logic [5:0]          Wr_Grant_ID;
  logic                Wr_Dat_Rdy;
  logic                GB_We;
  logic [ADDR_W-1:0]   GB_Addr;
  logic [DATA_W-1:0]   GB_Dat;
  logic                Wr_Done;
  logic                Wr_Abort;

  gb_write_ctrl #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .Wr_Req(Wr_Req), .Wr_ID(Wr_ID), .Wr_Dat_In(Wr_Dat_In),
    .Wr_Dat_Vld(Wr_Dat_Vld), .State_Wr(State_Wr), .Wr_Grant(Wr_Grant),
    .Wr_Grant_ID(Wr_Grant_ID), .Wr_Dat_Rdy(Wr_Dat_Rdy), .GB_We(GB_We), .GB_Addr(GB_Addr),
    .GB_Dat(GB_Dat), .Wr_Done(Wr_Done), .Wr_Abort(Wr_Abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              done;
  } wr_t;

  typedef struct {
    logic [5:0]        id;
    logic [5:0]        stale;
    bit                gapped;
    int                delay;
    bit                idx_data;
    logic [ADDR_W-1:0] base;
  } vec_t;

  wr_t        exp_q[$];
  logic [5:0] grant_q[$];
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every GB write and grant must match the next expected entry.
  always @(negedge clk) begin
    wr_t e;
    if (GB_We === 1'b1) begin
      if (exp_q.size() == 0) chk("gb_we_unexpected", 64'(GB_Addr), 64'h0);
      else begin
        e = exp_q.pop_front();
        chk("gb_addr", 64'(GB_Addr), 64'(e.addr));
        chk("gb_dat", GB_Dat, e.data);
        chk("wr_done", 64'(Wr_Done), 64'(e.done));
      end
    end else if (Wr_Done === 1'b1) begin
      chk("done_without_we", 64'(Wr_Done), 64'h0);
    end
    if (Wr_Grant === 1'b1) begin
      if (grant_q.size() == 0) chk("grant_unexpected", 64'(Wr_Grant_ID), 64'h0);
      else chk("grant_id_sb", 64'(Wr_Grant_ID), 64'(grant_q.pop_front()));
    end
  end

  // IDLE -> REQ_READY -> READY_TO_WRITE, holding a stale request and a dropped beat in REQ_READY.
  task automatic request(input logic [5:0] id, input logic [5:0] stale);
    chk("idle_state", 64'(State_Wr), 64'h0);
    chk("idle_rdy", 64'(Wr_Dat_Rdy), 64'h0);
    Wr_Req = 1'b1;
    Wr_ID  = id;
    grant_q.push_back(id);
    step();
    chk("rr_state", 64'(State_Wr), 64'h1);
    chk("rr_grant", 64'(Wr_Grant), 64'h1);
    chk("rr_rdy", 64'(Wr_Dat_Rdy), 64'h0);
    Wr_ID      = stale;
    Wr_Dat_Vld = 1'b1;
    Wr_Dat_In  = '1;
    step();
    Wr_Req     = 1'b0;
    Wr_ID      = '0;
    Wr_Dat_Vld = 1'b0;
    chk("rtw_state", 64'(State_Wr), 64'h3);
    chk("rtw_rdy", 64'(Wr_Dat_Rdy), 64'h1);
    chk("rtw_grant", 64'(Wr_Grant), 64'h0);
    chk("grant_id", 64'(Wr_Grant_ID), 64'(id));
  endtask

  task automatic send_beats(input logic [ADDR_W-1:0] base, input int n, input bit gapped,
                            input bit idx_data);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = base + ADDR_W'(i);
      e.data = idx_data ? 64'(i) : {$urandom, $urandom};
      e.done = (i == 15);
      exp_q.push_back(e);
      Wr_Dat_Vld = 1'b1;
      Wr_Dat_In  = e.data;
      step();
      if (i == 0) chk("write_state", 64'(State_Wr), 64'h2);
      if (gapped && i != 15) begin
        Wr_Dat_Vld = 1'b0;
        Wr_Dat_In  = {$urandom, $urandom};
        step();
      end
    end
    Wr_Dat_Vld = 1'b0;
  endtask

  task automatic do_burst(input vec_t v);
    request(v.id, v.stale);
    for (int d = 0; d < v.delay; d++) begin
      chk("wait_state", 64'(State_Wr), 64'h3);
      chk("wait_abort", 64'(Wr_Abort), 64'h0);
      step();
    end
    send_beats(v.base, 16, v.gapped, v.idx_data);
    chk("end_state", 64'(State_Wr), 64'h0);
    chk("end_done", 64'(Wr_Done), 64'h1);
    step();
    chk("idle2_state", 64'(State_Wr), 64'h0);
    chk("idle2_done", 64'(Wr_Done), 64'h0);
    chk("drained", 64'(exp_q.size()), 64'h0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_state", 64'(State_Wr), 64'h0);
    chk("rst_grant", 64'(Wr_Grant), 64'h0);
    chk("rst_grant_id", 64'(Wr_Grant_ID), 64'h0);
    chk("rst_rdy", 64'(Wr_Dat_Rdy), 64'h0);
    chk("rst_we", 64'(GB_We), 64'h0);
    chk("rst_addr", 64'(GB_Addr), 64'h0);
    chk("rst_dat", GB_Dat, 64'h0);
    chk("rst_done", 64'(Wr_Done), 64'h0);
    chk("rst_abort", 64'(Wr_Abort), 64'h0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{id: 6'h25, stale: 6'h25, gapped: 1'b0, delay: 0, idx_data: 1'b1, base: 10'h250};
    vecs[1] = '{id: 6'h3F, stale: 6'h3F, gapped: 1'b1, delay: 0, idx_data: 1'b0, base: 10'h3F0};
    vecs[2] = '{id: 6'h05, stale: 6'h06, gapped: 1'b0, delay: 0, idx_data: 1'b0, base: 10'h050};
    vecs[3] = '{id: 6'h01, stale: 6'h01, gapped: 1'b0, delay: 0, idx_data: 1'b0, base: 10'h010};
    vecs[4] = '{id: 6'h30, stale: 6'h30, gapped: 1'b0, delay: 2, idx_data: 1'b0, base: 10'h300};
    vecs[5] = '{id: 6'h12, stale: 6'h12, gapped: 1'b1, delay: TIMEOUT - 1, idx_data: 1'b0,
                base: 10'h120};

    rst        = 1'b1;
    Wr_Req     = 1'b0;
    Wr_ID      = '0;
    Wr_Dat_In  = '0;
    Wr_Dat_Vld = 1'b0;
    step();
    step();
    chk_reset_vals();
    rst = 1'b0;
    step();

    foreach (vecs[k]) do_burst(vecs[k]);

    // First-beat timeout, then a normal burst must follow.
    request(6'h10, 6'h10);
    for (int j = 0; j < int'(TIMEOUT); j++) begin
      chk("to_state", 64'(State_Wr), 64'h3);
      chk("to_abort_early", 64'(Wr_Abort), 64'h0);
      step();
    end
    chk("to_abort", 64'(Wr_Abort), 64'h1);
    chk("to_idle", 64'(State_Wr), 64'h0);
    chk("to_rdy", 64'(Wr_Dat_Rdy), 64'h0);
    step();
    chk("to_abort_clear", 64'(Wr_Abort), 64'h0);
    do_burst('{id: 6'h11, stale: 6'h11, gapped: 1'b0, delay: 0, idx_data: 1'b0, base: 10'h110});

    // Reset after beat 7, with beat 8 offered in the reset cycle.
    request(6'h2A, 6'h2A);
    send_beats(10'h2A0, 8, 1'b0, 1'b0);
    rst        = 1'b1;
    Wr_Dat_Vld = 1'b1;
    Wr_Dat_In  = {$urandom, $urandom};
    step();
    rst        = 1'b0;
    Wr_Dat_Vld = 1'b0;
    chk_reset_vals();
    chk("rst_drained", 64'(exp_q.size()), 64'h0);
    step();
    chk("rst_we_hold", 64'(GB_We), 64'h0);
    do_burst('{id: 6'h2A, stale: 6'h2A, gapped: 1'b0, delay: 0, idx_data: 1'b0, base: 10'h2A0});

    step();
    chk("grants_drained", 64'(grant_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
